// File: rtl/window_5x5_gen.sv
// Streaming 5x5 neighbourhood generator: four line buffers plus a 5x5 shift array.
// Optional centre-coordinate outputs ctr_x/ctr_y are enabled by defining WIN_CENTER_XY_EN.
module window_5x5_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic [199:0] window_out,
    output logic         window_valid,
`ifdef WIN_CENTER_XY_EN
    output logic [15:0]  ctr_x,
    output logic [15:0]  ctr_y,
`endif
    output logic         frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_row;
    logic          interior;

    // lb[c][0] is line row-1, lb[c][3] is line row-4
    logic [3:0][7:0] lb [IMG_WIDTH];
    logic [3:0][7:0] lb_rd;

    // win[i][j] sits at bit offset 8*(5*i+j), matching the window_out layout
    logic [4:0][4:0][7:0] win;
    logic [4:0][4:0][7:0] win_nxt;

    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));
    assign interior = (int'(row) >= 4) && (int'(col) >= 4);
    assign lb_rd    = lb[col];

    always_comb begin
        win_nxt = win;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                win_nxt[i][j] = win[i][j+1];
            end
        end
        win_nxt[0][4] = lb_rd[3];
        win_nxt[1][4] = lb_rd[2];
        win_nxt[2][4] = lb_rd[1];
        win_nxt[3][4] = lb_rd[0];
        win_nxt[4][4] = pix_in;
    end

    // Line buffers are deliberately not reset; rows 0..3 never expose them
    always_ff @(posedge clk) begin
        if (rst_n && pix_valid) begin
            lb[col] <= {lb_rd[2:0], pix_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win          <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= pix_valid && interior;
            frame_done   <= pix_valid && last_col && last_row;
            if (pix_valid) begin
                win <= win_nxt;
                if (interior) begin
                    window_out <= win_nxt;
                end
            end
        end
    end

`ifdef WIN_CENTER_XY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_x <= '0;
            ctr_y <= '0;
        end else if (pix_valid && interior) begin
            ctr_x <= 16'(col) - 16'd2;
            ctr_y <= 16'(row) - 16'd2;
        end
    end
`endif

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen on an 8x8 frame with hand-derived ramp windows.
module tb_window_5x5_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic         clk;
    logic         rst_n;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic [199:0] window_out;
    logic         window_valid;
    logic         frame_done;
`ifdef WIN_CENTER_XY_EN
    logic [15:0]  ctr_x;
    logic [15:0]  ctr_y;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [199:0] last_win;

    window_5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .window_out   (window_out),
        .window_valid (window_valid),
`ifdef WIN_CENTER_XY_EN
        .ctr_x        (ctr_x),
        .ctr_y        (ctr_y),
`endif
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix_val(int r, int c, bit inv);
        int v;
        v = 8 * r + c;
        if (inv) v = 255 - v;
        return v[7:0];
    endfunction

    function automatic logic [199:0] exp_win(int r, int c, bit inv);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[8*(5*i+j) +: 8] = pix_val(r - 4 + i, c - 4 + j, inv);
        return w;
    endfunction

    // Drives one cycle and samples 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [7:0] p);
        @(negedge clk);
        pix_valid = v;
        pix_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (window_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_window_out got=%h exp=0", window_out);
        end
        tests_run++;
        if (window_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_window_valid got=%b exp=0", window_valid);
        end
        tests_run++;
        if (frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
`ifdef WIN_CENTER_XY_EN
        tests_run++;
        if (ctr_x !== 16'd0 || ctr_y !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_ctr got=%0d,%0d exp=0,0", ctr_x, ctr_y);
        end
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        last_win  = '0;
    endtask

    task automatic test_ramp;
        int pulses = 0;
        int dones  = 0;
        bit intr;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, pix_val(r, c, 1'b0));
                intr = (r >= 4) && (c >= 4);
                if (window_valid) pulses++;
                if (frame_done) dones++;
                tests_run++;
                if (window_valid !== intr) begin
                    tests_failed++;
                    $display("FAIL ramp_valid r=%0d c=%0d got=%b exp=%b", r, c, window_valid, intr);
                end
                if (intr) begin
                    last_win = exp_win(r, c, 1'b0);
                    tests_run++;
                    if (window_out !== last_win) begin
                        tests_failed++;
                        $display("FAIL ramp_window r=%0d c=%0d got=%h exp=%h", r, c, window_out, last_win);
                    end
                end
                if (r == 4 && c == 4) begin
                    tests_run++;
                    if (window_out[7:0] !== 8'd0 || window_out[103:96] !== 8'd18 || window_out[199:192] !== 8'd36) begin
                        tests_failed++;
                        $display("FAIL ramp_first got=%0d/%0d/%0d exp=0/18/36",
                                 window_out[7:0], window_out[103:96], window_out[199:192]);
                    end
`ifdef WIN_CENTER_XY_EN
                    tests_run++;
                    if (ctr_x !== 16'd2 || ctr_y !== 16'd2) begin
                        tests_failed++;
                        $display("FAIL ramp_first_ctr got=%0d,%0d exp=2,2", ctr_x, ctr_y);
                    end
`endif
                end
                if (r == H - 1 && c == W - 1) begin
                    tests_run++;
                    if (window_out[103:96] !== 8'd45 || frame_done !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL ramp_last centre=%0d done=%b exp=45,1", window_out[103:96], frame_done);
                    end
`ifdef WIN_CENTER_XY_EN
                    tests_run++;
                    if (ctr_x !== 16'd5 || ctr_y !== 16'd5) begin
                        tests_failed++;
                        $display("FAIL ramp_last_ctr got=%0d,%0d exp=5,5", ctr_x, ctr_y);
                    end
`endif
                end
            end
        end
        tests_run++;
        if (pulses != 16 || dones != 1) begin
            tests_failed++;
            $display("FAIL ramp_counts pulses=%0d done=%0d exp=16,1", pulses, dones);
        end
    endtask

    task automatic test_gapped;
        int pulses = 0;
        bit intr;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, pix_val(r, c, 1'b0));
                intr = (r >= 4) && (c >= 4);
                if (window_valid) pulses++;
                tests_run++;
                if (window_valid !== intr) begin
                    tests_failed++;
                    $display("FAIL gap_valid r=%0d c=%0d got=%b exp=%b", r, c, window_valid, intr);
                end
                if (intr) begin
                    last_win = exp_win(r, c, 1'b0);
                    tests_run++;
                    if (window_out !== last_win) begin
                        tests_failed++;
                        $display("FAIL gap_window r=%0d c=%0d got=%h exp=%h", r, c, window_out, last_win);
                    end
                end
                drive(1'b0, 8'hEE);
                tests_run++;
                if (window_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== last_win) begin
                    tests_failed++;
                    $display("FAIL gap_idle r=%0d c=%0d valid=%b done=%b held=%b exp=0,0,1",
                             r, c, window_valid, frame_done, window_out === last_win);
                end
            end
        end
        tests_run++;
        if (pulses != 16) begin
            tests_failed++;
            $display("FAIL gap_pulses got=%0d exp=16", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int pulses[2] = '{0, 0};
        int dones[2]  = '{0, 0};
        bit intr;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    drive(1'b1, pix_val(r, c, f[0]));
                    intr = (r >= 4) && (c >= 4);
                    if (window_valid) pulses[f]++;
                    if (frame_done) dones[f]++;
                    tests_run++;
                    if (window_valid !== intr) begin
                        tests_failed++;
                        $display("FAIL b2b_valid f=%0d r=%0d c=%0d got=%b exp=%b", f, r, c, window_valid, intr);
                    end
                    if (intr) begin
                        last_win = exp_win(r, c, f[0]);
                        tests_run++;
                        if (window_out !== last_win) begin
                            tests_failed++;
                            $display("FAIL b2b_window f=%0d r=%0d c=%0d got=%h exp=%h", f, r, c, window_out, last_win);
                        end
                    end
                    if (f == 1 && r == 4 && c == 4) begin
                        tests_run++;
                        if (window_out[103:96] !== 8'd237) begin
                            tests_failed++;
                            $display("FAIL b2b_first_centre got=%0d exp=237", window_out[103:96]);
                        end
                    end
                end
            end
        end
        tests_run++;
        if (pulses[0] != 16 || pulses[1] != 16 || dones[0] != 1 || dones[1] != 1) begin
            tests_failed++;
            $display("FAIL b2b_counts pulses=%0d,%0d done=%0d,%0d exp=16,16,1,1",
                     pulses[0], pulses[1], dones[0], dones[1]);
        end
    endtask

    task automatic test_mid_reset;
        int pulses = 0;
        bit intr;
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 8'(n + 100));
            tests_run++;
            if (window_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_pre_valid n=%0d got=%b exp=0", n, window_valid);
            end
        end
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'd99;
        @(posedge clk);
        #1;
        tests_run++;
        if (window_out !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_state out_zero=%b valid=%b done=%b exp=1,0,0",
                     window_out === '0, window_valid, frame_done);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, pix_val(r, c, 1'b0));
                intr = (r >= 4) && (c >= 4);
                if (window_valid) pulses++;
                tests_run++;
                if (window_valid !== intr) begin
                    tests_failed++;
                    $display("FAIL mid_valid r=%0d c=%0d got=%b exp=%b", r, c, window_valid, intr);
                end
                if (intr) begin
                    tests_run++;
                    if (window_out !== exp_win(r, c, 1'b0)) begin
                        tests_failed++;
                        $display("FAIL mid_window r=%0d c=%0d got=%h exp=%h", r, c, window_out, exp_win(r, c, 1'b0));
                    end
                end
            end
        end
        tests_run++;
        if (pulses != 16) begin
            tests_failed++;
            $display("FAIL mid_pulses got=%0d exp=16", pulses);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 8'd0;
        last_win  = '0;
        test_reset;
        test_ramp;
        test_gapped;
        test_back_to_back;
        test_mid_reset;
        drive(1'b0, 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
